minmax_tracker: RTL and testbench

MINMAX_TRACKER -- requirements
Module: minmax_tracker

---
 rtl/minmax_tracker.sv | 203 ++++++++++++++++++++
 tb/tb_minmax_tracker.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/minmax_tracker.sv
// -----------------------------------------------------------------------------
// minmax_tracker
//   Frame-based running minimum / maximum tracker. Accepts FRAME_LEN samples
//   per frame through a valid/ready handshake, tracks the smallest and largest
//   sample with their 0-based positions, and presents the results for one
//   cycle with an out_valid pulse. Compare mode (signed/unsigned) is latched at
//   the first sample of each frame.
//
//   Optional feature: define MINMAX_RANGE_EN to add the range_val output
//   (max_val - min_val, DATA_W+1 bits, mode-aware).
// -----------------------------------------------------------------------------
module minmax_tracker #(
  parameter int DATA_W    = 8,
  parameter int FRAME_LEN = 16,
  parameter int IDX_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              signed_mode,
  input  logic              clear,
  output logic [DATA_W-1:0] min_val,
  output logic [DATA_W-1:0] max_val,
  output logic [IDX_W-1:0]  min_idx,
  output logic [IDX_W-1:0]  max_idx,
  output logic              out_valid,
`ifdef MINMAX_RANGE_EN
  output logic [DATA_W:0]   range_val,
`endif
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Position of the sample that completes a frame.
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    count_q, count_d;
  logic                mode_q, mode_d;
  logic [DATA_W-1:0]   run_min_q, run_min_d;
  logic [DATA_W-1:0]   run_max_q, run_max_d;
  logic [IDX_W-1:0]    run_min_idx_q, run_min_idx_d;
  logic [IDX_W-1:0]    run_max_idx_q, run_max_idx_d;
  logic [DATA_W-1:0]   res_min_q, res_min_d;
  logic [DATA_W-1:0]   res_max_q, res_max_d;
  logic [IDX_W-1:0]    res_min_idx_q, res_min_idx_d;
  logic [IDX_W-1:0]    res_max_idx_q, res_max_idx_d;
  logic                out_valid_q, out_valid_d;
`ifdef MINMAX_RANGE_EN
  logic [DATA_W:0]     range_q, range_d;
`endif
  logic                accept;

  // Strict less-than under the frame's compare mode; strictness keeps the
  // earliest index on ties.
  function automatic logic is_less(input logic [DATA_W-1:0] a,
                                   input logic [DATA_W-1:0] b,
                                   input logic              sgn);
    if (sgn) return $signed(a) < $signed(b);
    else     return a < b;
  endfunction

  assign in_ready  = (state_q != DONE);
  assign accept    = in_valid && in_ready;
  assign busy      = (state_q == ACCUM);
  assign out_valid = out_valid_q;
  assign min_val   = res_min_q;
  assign max_val   = res_max_q;
  assign min_idx   = res_min_idx_q;
  assign max_idx   = res_max_idx_q;
`ifdef MINMAX_RANGE_EN
  assign range_val = range_q;
`endif

  // Next-state and datapath update: accumulate, publish in DONE, clear aborts.
  always_comb begin
    // NOTE: every _d gets a hold default first so no path leaves a latch.
    state_d       = state_q;
    count_d       = count_q;
    mode_d        = mode_q;
    run_min_d     = run_min_q;
    run_max_d     = run_max_q;
    run_min_idx_d = run_min_idx_q;
    run_max_idx_d = run_max_idx_q;
    res_min_d     = res_min_q;
    res_max_d     = res_max_q;
    res_min_idx_d = res_min_idx_q;
    res_max_idx_d = res_max_idx_q;
    out_valid_d   = 1'b0;
`ifdef MINMAX_RANGE_EN
    range_d       = range_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          run_min_d     = in_data;
          run_max_d     = in_data;
          run_min_idx_d = '0;
          run_max_idx_d = '0;
          count_d       = IDX_W'(1);
          mode_d        = signed_mode;
          state_d       = (FRAME_LEN == 1) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          if (is_less(in_data, run_min_q, mode_q)) begin
            run_min_d     = in_data;
            run_min_idx_d = count_q;
          end
          if (is_less(run_max_q, in_data, mode_q)) begin
            run_max_d     = in_data;
            run_max_idx_d = count_q;
          end
          count_d = count_q + IDX_W'(1);
          if (count_q == LAST_IDX) state_d = DONE;
        end
      end
      DONE: begin
        res_min_d     = run_min_q;
        res_max_d     = run_max_q;
        res_min_idx_d = run_min_idx_q;
        res_max_idx_d = run_max_idx_q;
        out_valid_d   = 1'b1;
        state_d       = IDLE;
`ifdef MINMAX_RANGE_EN
        // Extend by the frame's sign rule so the difference is exact.
        if (mode_q)
          range_d = {run_max_q[DATA_W-1], run_max_q} - {run_min_q[DATA_W-1], run_min_q};
        else
          range_d = {1'b0, run_max_q} - {1'b0, run_min_q};
`endif
      end
      default: state_d = IDLE;
    endcase

    // Abort wins over everything: drop the frame, keep published results.
    if (clear) begin
      state_d       = IDLE;
      count_d       = '0;
      mode_d        = 1'b0;
      run_min_d     = '0;
      run_max_d     = '0;
      run_min_idx_d = '0;
      run_max_idx_d = '0;
      res_min_d     = res_min_q;
      res_max_d     = res_max_q;
      res_min_idx_d = res_min_idx_q;
      res_max_idx_d = res_max_idx_q;
      out_valid_d   = 1'b0;
`ifdef MINMAX_RANGE_EN
      range_d       = range_q;
`endif
    end
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      count_q       <= '0;
      mode_q        <= 1'b0;
      run_min_q     <= '0;
      run_max_q     <= '0;
      run_min_idx_q <= '0;
      run_max_idx_q <= '0;
      res_min_q     <= '0;
      res_max_q     <= '0;
      res_min_idx_q <= '0;
      res_max_idx_q <= '0;
      out_valid_q   <= 1'b0;
`ifdef MINMAX_RANGE_EN
      range_q       <= '0;
`endif
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      state_q       <= state_d;
      count_q       <= count_d;
      mode_q        <= mode_d;
      run_min_q     <= run_min_d;
      run_max_q     <= run_max_d;
      run_min_idx_q <= run_min_idx_d;
      run_max_idx_q <= run_max_idx_d;
      res_min_q     <= res_min_d;
      res_max_q     <= res_max_d;
      res_min_idx_q <= res_min_idx_d;
      res_max_idx_q <= res_max_idx_d;
      out_valid_q   <= out_valid_d;
`ifdef MINMAX_RANGE_EN
      range_q       <= range_d;
`endif
    end
  end

endmodule

// File: tb/tb_minmax_tracker.sv
// -----------------------------------------------------------------------------
// tb_minmax_tracker
//   Directed bench for minmax_tracker (DATA_W=8, FRAME_LEN=4). Each scenario
//   task drives its own vectors and compares against hand-computed values.
//   Range checks are compiled in when MINMAX_RANGE_EN is defined.
// -----------------------------------------------------------------------------
module tb_minmax_tracker;

  localparam int DATA_W    = 8;
  localparam int FRAME_LEN = 4;
  localparam int IDX_W     = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              signed_mode;
  logic              clear;
  logic [DATA_W-1:0] min_val;
  logic [DATA_W-1:0] max_val;
  logic [IDX_W-1:0]  min_idx;
  logic [IDX_W-1:0]  max_idx;
  logic              out_valid;
  logic              busy;
`ifdef MINMAX_RANGE_EN
  logic [DATA_W:0]   range_val;
`endif

  int n_vec = 0;
  int n_err = 0;

  logic [48:0] got, exp_v;
  logic        ov_seen;

  minmax_tracker #(
    .DATA_W    (DATA_W),
    .FRAME_LEN (FRAME_LEN),
    .IDX_W     (IDX_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .signed_mode (signed_mode),
    .clear       (clear),
    .min_val     (min_val),
    .max_val     (max_val),
    .min_idx     (min_idx),
    .max_idx     (max_idx),
    .out_valid   (out_valid),
`ifdef MINMAX_RANGE_EN
    .range_val   (range_val),
`endif
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Packs the observed result bundle {out_valid, min, min_idx, max, max_idx}.
  function automatic logic [48:0] observed();
    return {out_valid, min_val, min_idx, max_val, max_idx};
  endfunction

  // Packs an expected result bundle in the same layout.
  function automatic logic [48:0] expect_res(input logic ov, input logic [7:0] mn,
                                             input logic [15:0] mi, input logic [7:0] mx,
                                             input logic [15:0] xi);
    return {ov, mn, mi, mx, xi};
  endfunction

  // Idles for gap cycles, then presents one sample until it is accepted.
  task automatic push(input logic [7:0] d, input int gap);
    int t;
    in_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
    in_data  = d;
    in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 8) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) begin
      n_vec++; n_err++;
      $display("FAIL push_timeout: in_ready=%b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; signed_mode = 1'b0; clear = 1'b0;
    #2;
    got = observed(); exp_v = '0;
    n_vec++;
    if (got !== exp_v) begin
      n_err++; $display("FAIL reset_results: got %h required %h", got, exp_v);
    end
    n_vec++;
    if ({in_ready, busy} !== 2'b10) begin
      n_err++; $display("FAIL reset_ready_busy: got %b required 10", {in_ready, busy});
    end
`ifdef MINMAX_RANGE_EN
    n_vec++;
    if (range_val !== 9'd0) begin
      n_err++; $display("FAIL reset_range: got %0d required 0", range_val);
    end
`endif
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_unsigned_basic();
    signed_mode = 1'b0;
    push(8'd10, 0);
    n_vec++;
    if (busy !== 1'b1) begin
      n_err++; $display("FAIL s1_busy_accum: got %b required 1", busy);
    end
    push(8'd200, 0); push(8'd3, 0); push(8'd200, 0);
    n_vec++;
    if ({out_valid, in_ready, busy} !== 3'b000) begin
      n_err++; $display("FAIL s1_done_state: got %b required 000", {out_valid, in_ready, busy});
    end
    @(posedge clk); #1;
    got = observed(); exp_v = expect_res(1'b1, 8'd3, 16'd2, 8'd200, 16'd1);
    n_vec++;
    if (got !== exp_v) begin
      n_err++; $display("FAIL s1_result: got %h required %h", got, exp_v);
    end
    @(posedge clk); #1;
    got = observed(); exp_v = expect_res(1'b0, 8'd3, 16'd2, 8'd200, 16'd1);
    n_vec++;
    if (got !== exp_v) begin
      n_err++; $display("FAIL s1_hold: got %h required %h", got, exp_v);
    end
  endtask

  task automatic test_signed_vs_unsigned();
    signed_mode = 1'b1;
    push(8'h7F, 0); push(8'h80, 0); push(8'h00, 0); push(8'hFF, 0);
    @(posedge clk); #1;
    got = observed(); exp_v = expect_res(1'b1, 8'h80, 16'd1, 8'h7F, 16'd0);
    n_vec++;
    if (got !== exp_v) begin
      n_err++; $display("FAIL s2_signed: got %h required %h", got, exp_v);
    end
    signed_mode = 1'b0;
    push(8'h7F, 0); push(8'h80, 0); push(8'h00, 0); push(8'hFF, 0);
    @(posedge clk); #1;
    got = observed(); exp_v = expect_res(1'b1, 8'h00, 16'd2, 8'hFF, 16'd3);
    n_vec++;
    if (got !== exp_v) begin
      n_err++; $display("FAIL s2_unsigned: got %h required %h", got, exp_v);
    end
  endtask

  task automatic test_gaps_mode_toggle();
    signed_mode = 1'b0;
    push(8'd10, 0);
    signed_mode = 1'b1;
    push(8'd200, 1);
    got = observed(); exp_v = expect_res(1'b0, 8'h00, 16'd2, 8'hFF, 16'd3);
    n_vec++;
    if (got !== exp_v) begin
      n_err++; $display("FAIL s3_held_midframe: got %h required %h", got, exp_v);
    end
    push(8'd3, 2);
    signed_mode = 1'b0;
    push(8'd200, 3);
    signed_mode = 1'b1;
    n_vec++;
    if ({out_valid, in_ready} !== 2'b00) begin
      n_err++; $display("FAIL s3_done_state: got %b required 00", {out_valid, in_ready});
    end
    @(posedge clk); #1;
    got = observed(); exp_v = expect_res(1'b1, 8'd3, 16'd2, 8'd200, 16'd1);
    n_vec++;
    if (got !== exp_v) begin
      n_err++; $display("FAIL s3_result: got %h required %h", got, exp_v);
    end
    signed_mode = 1'b0;
  endtask

  task automatic test_clear();
    push(8'd50, 0); push(8'd60, 0);
    clear = 1'b1; in_valid = 1'b1; in_data = 8'd0;
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    n_vec++;
    if ({busy, in_ready, out_valid} !== 3'b010) begin
      n_err++; $display("FAIL s4_after_clear: got %b required 010", {busy, in_ready, out_valid});
    end
    got = observed(); exp_v = expect_res(1'b0, 8'd3, 16'd2, 8'd200, 16'd1);
    n_vec++;
    if (got !== exp_v) begin
      n_err++; $display("FAIL s4_results_held: got %h required %h", got, exp_v);
    end
    ov_seen = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      ov_seen = ov_seen | out_valid;
    end
    n_vec++;
    if (ov_seen !== 1'b0) begin
      n_err++; $display("FAIL s4_no_pulse: got %b required 0", ov_seen);
    end
    push(8'd5, 0); push(8'd6, 0); push(8'd7, 0); push(8'd8, 0);
    @(posedge clk); #1;
    got = observed(); exp_v = expect_res(1'b1, 8'd5, 16'd0, 8'd8, 16'd3);
    n_vec++;
    if (got !== exp_v) begin
      n_err++; $display("FAIL s4_fresh_frame: got %h required %h", got, exp_v);
    end
    // Clear arriving in DONE suppresses the pulse and the update.
    push(8'd20, 0); push(8'd30, 0); push(8'd40, 0); push(8'd10, 0);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    got = observed(); exp_v = expect_res(1'b0, 8'd5, 16'd0, 8'd8, 16'd3);
    n_vec++;
    if (got !== exp_v) begin
      n_err++; $display("FAIL s4_clear_in_done: got %h required %h", got, exp_v);
    end
    n_vec++;
    if ({in_ready, busy} !== 2'b10) begin
      n_err++; $display("FAIL s4_idle_after_done_clear: got %b required 10", {in_ready, busy});
    end
  endtask

  task automatic test_reset_midframe();
    push(8'd1, 0); push(8'd2, 0); push(8'd3, 0);
    #2 rst_n = 1'b0;
    #1;
    got = observed(); exp_v = '0;
    n_vec++;
    if (got !== exp_v) begin
      n_err++; $display("FAIL s5_async_reset: got %h required %h", got, exp_v);
    end
    n_vec++;
    if ({in_ready, busy} !== 2'b10) begin
      n_err++; $display("FAIL s5_reset_ready_busy: got %b required 10", {in_ready, busy});
    end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    ov_seen = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      ov_seen = ov_seen | out_valid;
    end
    n_vec++;
    if (ov_seen !== 1'b0) begin
      n_err++; $display("FAIL s5_no_pulse: got %b required 0", ov_seen);
    end
    push(8'd10, 0); push(8'd200, 0); push(8'd3, 0); push(8'd200, 0);
    @(posedge clk); #1;
    got = observed(); exp_v = expect_res(1'b1, 8'd3, 16'd2, 8'd200, 16'd1);
    n_vec++;
    if (got !== exp_v) begin
      n_err++; $display("FAIL s5_next_frame: got %h required %h", got, exp_v);
    end
  endtask

  task automatic test_back_to_back();
    push(8'd9, 0); push(8'd9, 0); push(8'd9, 0); push(8'd9, 0);
    // Next frame's first sample is already waiting while the DUT is in DONE.
    in_data = 8'h80; in_valid = 1'b1;
    @(posedge clk); #1;
    got = observed(); exp_v = expect_res(1'b1, 8'd9, 16'd0, 8'd9, 16'd0);
    n_vec++;
    if (got !== exp_v) begin
      n_err++; $display("FAIL b2b_ties_frame: got %h required %h", got, exp_v);
    end
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL b2b_ready_after_done: got %b required 1", in_ready);
    end
    push(8'h80, 0); push(8'h7F, 0); push(8'h01, 0); push(8'h80, 0);
    @(posedge clk); #1;
    got = observed(); exp_v = expect_res(1'b1, 8'h01, 16'd2, 8'h80, 16'd0);
    n_vec++;
    if (got !== exp_v) begin
      n_err++; $display("FAIL b2b_second_frame: got %h required %h", got, exp_v);
    end
  endtask

`ifdef MINMAX_RANGE_EN
  task automatic test_range();
    signed_mode = 1'b0;
    push(8'd10, 0); push(8'd200, 0); push(8'd3, 0); push(8'd200, 0);
    @(posedge clk); #1;
    n_vec++;
    if ({out_valid, range_val} !== {1'b1, 9'd197}) begin
      n_err++; $display("FAIL range_unsigned: got %b/%0d required 1/197", out_valid, range_val);
    end
    signed_mode = 1'b1;
    push(8'h7F, 0); push(8'h80, 0); push(8'h7F, 0); push(8'h80, 0);
    @(posedge clk); #1;
    n_vec++;
    if ({out_valid, range_val} !== {1'b1, 9'd255}) begin
      n_err++; $display("FAIL range_signed: got %b/%0d required 1/255", out_valid, range_val);
    end
    signed_mode = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_unsigned_basic();
    test_signed_vs_unsigned();
    test_gaps_mode_toggle();
    test_clear();
    test_reset_midframe();
    test_back_to_back();
`ifdef MINMAX_RANGE_EN
    test_range();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
